// File: rtl/xpb_accum_pkg.sv
// Shared sizes, state encoding and vector types for the xpb column accumulator.
// Every other file in this block imports this package.
package xpb_accum_pkg;

  localparam int REDUCT_SEGMENT    = 19;
  localparam int NONREDUCT_SEGMENT = 16;
  localparam int BIT_LEN           = 17;
  localparam int NUM_XPB           = 3 * REDUCT_SEGMENT;

  // Width that holds (num_rows + 1) full-scale terms without overflow.
  function automatic int acc_len_f(input int bit_len, input int num_rows);
    return bit_len + $clog2(num_rows + 1);
  endfunction

  localparam int ACC_LEN = acc_len_f(BIT_LEN, NUM_XPB);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  typedef logic [BIT_LEN-1:0]                elem_t;
  typedef elem_t [NONREDUCT_SEGMENT-1:0]     row_t;
  typedef row_t [NUM_XPB-1:0]                xpb_t;
  typedef logic [ACC_LEN-1:0]                acc_elem_t;
  typedef acc_elem_t [NONREDUCT_SEGMENT-1:0] col_vec_t;

endpackage

// File: rtl/xpb_accum_if.sv
// Operand/result bus between the xpb lookup stage, the accumulator and its consumer.
// Handshake: a transfer happens on a clk edge where valid && ready; ready never depends on valid.
interface xpb_accum_if;
  import xpb_accum_pkg::*;

  logic     in_valid;
  logic     in_ready;
  row_t     low_segment;
  xpb_t     all_xpb;
  logic     out_valid;
  logic     out_ready;
  col_vec_t out_col;

  modport master (
    output in_valid,
    input  in_ready,
    output low_segment,
    output all_xpb,
    input  out_valid,
    output out_ready,
    input  out_col
  );

  modport slave (
    input  in_valid,
    output in_ready,
    input  low_segment,
    input  all_xpb,
    output out_valid,
    input  out_ready,
    output out_col
  );

endinterface

// File: rtl/xpb_row_adder.sv
// Combinational step of the accumulator: adds a group of xpb rows into the column sums.
// Rows whose valid bit is low contribute nothing (tail of the last group).
module xpb_row_adder
  import xpb_accum_pkg::*;
#(
  parameter int ROWS = 3
) (
  input  col_vec_t              acc_i,
  input  row_t [ROWS-1:0]       rows_i,
  input  logic [ROWS-1:0]       row_vld_i,
  output col_vec_t              acc_o
);

  always_comb begin
    acc_o = acc_i;
    for (int r = 0; r < ROWS; r++) begin
      if (row_vld_i[r]) begin
        for (int j = 0; j < NONREDUCT_SEGMENT; j++) begin
          acc_o[j] = acc_o[j] + acc_elem_t'(rows_i[r][j]);
        end
      end
    end
  end

endmodule

// File: rtl/xpb_accum.sv
// Iterative column accumulator: low segments plus all xpb rows, ROWS_PER_CYCLE rows per clock.
// Produces uncarried per-column sums; one operation in flight.
module xpb_accum
  import xpb_accum_pkg::*;
#(
  parameter int ROWS_PER_CYCLE = 3
) (
  input  logic         clk,
  input  logic         reset,
  xpb_accum_if.slave   bus,
  output state_t       dbg_state_o
);

  localparam int IDX_W     = $clog2(NUM_XPB + ROWS_PER_CYCLE + 1);
  localparam int GRP_SHIFT = ROWS_PER_CYCLE * $bits(row_t);

  if (ROWS_PER_CYCLE < 1 || ROWS_PER_CYCLE > NUM_XPB) begin : g_bad_rows
    $error("xpb_accum: ROWS_PER_CYCLE must be in 1..NUM_XPB");
  end

  state_t                         state_q, state_d;
  logic [IDX_W-1:0]               row_idx_q, row_idx_d;
  col_vec_t                       acc_q, acc_d, acc_sum;
  xpb_t                           xpb_buf_q, xpb_buf_d;
  row_t [ROWS_PER_CYCLE-1:0]      grp_rows;
  logic [ROWS_PER_CYCLE-1:0]      grp_vld;
  logic                           last_grp;

  // The buffer shifts down one group per ACCUM cycle, so the current group
  // always sits in the lowest rows; row_idx only drives the mask and the exit.
  assign grp_rows = xpb_buf_q[ROWS_PER_CYCLE-1:0];
  assign last_grp = (row_idx_q + IDX_W'(ROWS_PER_CYCLE)) >= IDX_W'(NUM_XPB);

  always_comb begin
    grp_vld = '0;
    for (int r = 0; r < ROWS_PER_CYCLE; r++) begin
      grp_vld[r] = (row_idx_q + IDX_W'(r)) < IDX_W'(NUM_XPB);
    end
  end

  xpb_row_adder #(
    .ROWS (ROWS_PER_CYCLE)
  ) u_row_adder (
    .acc_i     (acc_q),
    .rows_i    (grp_rows),
    .row_vld_i (grp_vld),
    .acc_o     (acc_sum)
  );

  always_comb begin
    state_d   = state_q;
    row_idx_d = row_idx_q;
    acc_d     = acc_q;
    xpb_buf_d = xpb_buf_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          xpb_buf_d = bus.all_xpb;
          for (int j = 0; j < NONREDUCT_SEGMENT; j++) begin
            acc_d[j] = acc_elem_t'(bus.low_segment[j]);
          end
          row_idx_d = '0;
          state_d   = ACCUM;
        end
      end
      ACCUM: begin
        acc_d     = acc_sum;
        row_idx_d = row_idx_q + IDX_W'(ROWS_PER_CYCLE);
        xpb_buf_d = xpb_buf_q >> GRP_SHIFT;
        if (last_grp) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      row_idx_q <= '0;
      acc_q     <= '0;
    end else begin
      state_q   <= state_d;
      row_idx_q <= row_idx_d;
      acc_q     <= acc_d;
    end
  end

  // Operand buffer carries no reset: it is always loaded before it is read.
  always_ff @(posedge clk) begin
    xpb_buf_q <= xpb_buf_d;
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.out_col   = acc_q;
  assign dbg_state_o   = state_q;

endmodule
